// File: rtl/unibus_dma_master_pkg.sv
// unibus_dma_master_pkg: FSM state encoding, Unibus cycle codes and ARM ID shared by the DMA master files
package unibus_dma_master_pkg;
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_REQ     = 4'd1,
        S_GRANT   = 4'd2,
        S_WAITBUS = 4'd3,
        S_DESKEW  = 4'd4,
        S_MSYN    = 4'd5,
        S_UNSYN   = 4'd6,
        S_RELEASE = 4'd7
    } state_t;
    localparam logic [1:0] DATI  = 2'b00;
    localparam logic [1:0] DATIP = 2'b01;
    localparam logic [1:0] DATO  = 2'b10;
    localparam logic [1:0] DATOB = 2'b11;
    localparam logic [31:0] ARM_ID = 32'h444D1001;
endpackage

// File: rtl/unibus_arb.sv
// unibus_arb: NPR/NPG/SACK arbitration step; returns the current state unchanged outside IDLE/REQ/GRANT
module unibus_arb
    import unibus_dma_master_pkg::*;
(
    input  state_t state,
    input  logic   go,
    input  logic   npg_in_h,
    input  logic   bbsy_in_h,
    input  logic   ssyn_in_h,
    output state_t arb_next
);
    // the previous master must be fully off the bus before we take BBSY
    always_comb begin
        arb_next = state == S_IDLE && go ? S_REQ :
                   state == S_REQ && npg_in_h ? S_GRANT :
                   state == S_GRANT && !npg_in_h && !bbsy_in_h && !ssyn_in_h ? S_WAITBUS :
                   state;
    end
endmodule

// File: rtl/unibus_dma_master.sv
// unibus_dma_master: ARM-driven single-word Unibus NPR master (DATI/DATIP/DATO/DATOB) with NXM timeout
module unibus_dma_master
    import unibus_dma_master_pkg::*;
#(
    parameter int DESKEW  = 15,
    parameter int TIMEOUT = 1000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [3:0]  armraddr,
    input  logic [3:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic        armintrq,
    input  logic        init_in_h,
    output logic        npr_out_h,
    input  logic        npg_in_h,
    output logic        sack_out_h,
    input  logic        bbsy_in_h,
    output logic        bbsy_out_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    input  logic [15:0] d_in_h,
    output logic        msyn_out_h,
    input  logic        ssyn_in_h
);
    localparam int DW = DESKEW > 1 ? $clog2(DESKEW) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, nxt, arb_next;
    logic [17:0]   addr;
    logic [1:0]    cyc;
    logic [15:0]   wdata, rdata;
    logic          ie, done, nxm, busy, go, bus_on, timeout;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] tcnt;
    logic          unused_wdata;

    assign unused_wdata = ^armwdata[27:20];
    assign busy = state != S_IDLE;
    assign go = armwrite && armwaddr == 4'd1 && armwdata[31] && !busy && !init_in_h;
    assign timeout = tcnt == TW'(TIMEOUT - 1);
    assign bus_on = nxt inside {S_WAITBUS, S_DESKEW, S_MSYN, S_UNSYN};
    assign armintrq = done & ie;

    unibus_arb u_arb (
        .state    (state),
        .go       (go),
        .npg_in_h (npg_in_h),
        .bbsy_in_h(bbsy_in_h),
        .ssyn_in_h(ssyn_in_h),
        .arb_next (arb_next)
    );

    // WAITBUS already counts as the first deskew clock, so MSYN lands DESKEW clocks after the address
    always_comb begin
        nxt = arb_next;
        case (state)
            S_WAITBUS, S_DESKEW: nxt = dcnt == '0 ? S_MSYN : S_DESKEW;
            S_MSYN:    nxt = ssyn_in_h || timeout ? S_UNSYN : S_MSYN;
            S_UNSYN:   nxt = ssyn_in_h ? S_UNSYN : S_RELEASE;
            S_RELEASE: nxt = S_IDLE;
            default:   ;
        endcase
        if (init_in_h) nxt = S_IDLE;
    end

    always_comb begin
        armrdata = armraddr == 4'd0 ? ARM_ID :
                   armraddr == 4'd1 ? {busy, 11'b0, cyc, addr} :
                   armraddr == 4'd2 ? {rdata, wdata} :
                   armraddr == 4'd3 ? {busy, done, nxm, ie, 24'b0, state} :
                   32'b0;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= S_IDLE;
            addr       <= '0;
            cyc        <= '0;
            wdata      <= '0;
            rdata      <= '0;
            ie         <= 1'b0;
            done       <= 1'b0;
            nxm        <= 1'b0;
            dcnt       <= '0;
            tcnt       <= '0;
            npr_out_h  <= 1'b0;
            sack_out_h <= 1'b0;
            bbsy_out_h <= 1'b0;
            msyn_out_h <= 1'b0;
            a_out_h    <= '0;
            c_out_h    <= '0;
            d_out_h    <= '0;
        end else begin
            state      <= nxt;
            npr_out_h  <= nxt == S_REQ;
            sack_out_h <= nxt == S_GRANT;
            bbsy_out_h <= bus_on;
            msyn_out_h <= nxt == S_MSYN;
            dcnt       <= state == S_GRANT ? DW'(DESKEW - 1) : dcnt == '0 ? dcnt : dcnt - DW'(1);
            tcnt       <= state == S_MSYN ? tcnt + TW'(1) : '0;
            // bus lines are captured once so ARM register writes cannot disturb a running cycle
            if (!bus_on) begin
                a_out_h <= '0;
                c_out_h <= '0;
                d_out_h <= '0;
            end else if (state == S_GRANT) begin
                a_out_h <= addr;
                c_out_h <= cyc;
                d_out_h <= cyc[1] ? wdata : 16'b0;
            end
            if (state == S_MSYN && !init_in_h && ssyn_in_h && !c_out_h[1]) rdata <= d_in_h;
            if (state == S_MSYN && !init_in_h && !ssyn_in_h && timeout) nxm <= 1'b1;
            if (armwrite && !init_in_h) begin
                case (armwaddr)
                    4'd1: begin
                        addr <= armwdata[17:0];
                        cyc  <= armwdata[19:18];
                    end
                    4'd2: wdata <= armwdata[15:0];
                    4'd3: begin
                        ie <= armwdata[28];
                        if (armwdata[30]) done <= 1'b0;
                        if (armwdata[29]) nxm <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (go) begin
                done <= 1'b0;
                nxm  <= 1'b0;
            end
            if (state == S_RELEASE) done <= 1'b1;
            if (init_in_h && busy) begin
                done <= 1'b1;
                nxm  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_unibus_dma_master.sv
// tb_unibus_dma_master: directed Unibus master scenarios checked against a register/bus-level model
module tb_unibus_dma_master;
    localparam int DESKEW  = 15;
    localparam int TIMEOUT = 1000;

    logic        CLOCK = 1'b0, RESET = 1'b1;
    logic        armwrite = 1'b0;
    logic [3:0]  armraddr = '0, armwaddr = '0;
    logic [31:0] armwdata = '0, armrdata;
    logic        armintrq;
    logic        init_in_h = 1'b0, npr_out_h, npg_in_h = 1'b0, sack_out_h;
    logic        bbsy_in_h = 1'b0, bbsy_out_h, msyn_out_h, ssyn_in_h = 1'b0;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h, d_in_h = '0;

    unibus_dma_master #(.DESKEW(DESKEW), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
        .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata), .armintrq(armintrq),
        .init_in_h(init_in_h), .npr_out_h(npr_out_h), .npg_in_h(npg_in_h), .sack_out_h(sack_out_h),
        .bbsy_in_h(bbsy_in_h), .bbsy_out_h(bbsy_out_h), .a_out_h(a_out_h), .c_out_h(c_out_h),
        .d_out_h(d_out_h), .d_in_h(d_in_h), .msyn_out_h(msyn_out_h), .ssyn_in_h(ssyn_in_h)
    );

    always #5 CLOCK = ~CLOCK;

    int passed = 0, total = 0;
    // model of the ARM-visible registers and of the bus lines a cycle must present
    logic [17:0] m_addr = '0, m_bus_addr = '0;
    logic [1:0]  m_c = '0, m_bus_c = '0;
    logic [15:0] m_wdata = '0, m_rdata = '0, m_bus_d = '0;
    logic        m_ie = 1'b0, m_done = 1'b0, m_nxm = 1'b0, m_busy = 1'b0;
    logic        mon_idle = 1'b0, mon_bus = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge CLOCK) begin
        if (mon_bus) begin
            chk("npr_sack_exclusive", npr_out_h & sack_out_h, 0);
            chk("msyn_needs_bbsy", msyn_out_h & ~bbsy_out_h, 0);
            chk("bus_lines", {a_out_h, c_out_h, d_out_h},
                bbsy_out_h ? {m_bus_addr, m_bus_c, m_bus_d} : 36'd0);
        end
        if (mon_idle) begin
            chk("idle_ctl", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h}, 0);
            chk("intrq", armintrq, m_done & m_ie);
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    function automatic logic sig(input int k);
        case (k)
            0: return npr_out_h;
            1: return sack_out_h;
            2: return bbsy_out_h;
            3: return msyn_out_h;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int k, input logic v, input int lim, output int n);
        n = 0;
        while (sig(k) !== v && n < lim) begin
            tick();
            n++;
        end
        if (sig(k) !== v) chk($sformatf("wait_sig%0d_timeout", k), sig(k), v);
    endtask

    task automatic arm_rd(input logic [3:0] r, output logic [31:0] d);
        armraddr = r;
        #1 d = armrdata;
    endtask

    task automatic arm_wr(input logic [3:0] r, input logic [31:0] d);
        logic is_go;
        is_go = r == 4'd1 && d[31] && !m_busy;
        if (is_go) mon_idle = 1'b0;
        armwaddr = r;
        armwdata = d;
        armwrite = 1'b1;
        tick();
        armwrite = 1'b0;
        case (r)
            4'd1: begin
                m_addr = d[17:0];
                m_c = d[19:18];
            end
            4'd2: m_wdata = d[15:0];
            4'd3: begin
                m_ie = d[28];
                if (d[30]) m_done = 1'b0;
                if (d[29]) m_nxm = 1'b0;
            end
            default: ;
        endcase
        if (is_go) begin
            m_done = 1'b0;
            m_nxm = 1'b0;
            m_busy = 1'b1;
            m_bus_addr = m_addr;
            m_bus_c = m_c;
            m_bus_d = m_c[1] ? m_wdata : 16'd0;
            chk("go_to_npr", npr_out_h, 1);
        end
    endtask

    task automatic done_cycle(input bit nx, input bit rd, input logic [15:0] data);
        m_done = 1'b1;
        if (nx) m_nxm = 1'b1;
        if (rd) m_rdata = data;
        m_busy = 1'b0;
        mon_idle = 1'b1;
    endtask

    // plays the bus arbiter, then measures address-valid to MSYN
    task automatic grant(input int hold, input int bhold);
        int n;
        npg_in_h = 1'b1;
        tick();
        chk("sack_rise_npr_drop", {sack_out_h, npr_out_h}, 2'b10);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_npg", {sack_out_h, bbsy_out_h}, 2'b10);
        end
        npg_in_h = 1'b0;
        bbsy_in_h = bhold > 0;
        for (int i = 0; i < bhold; i++) begin
            tick();
            chk("hold_bbsy_in", {sack_out_h, bbsy_out_h}, 2'b10);
        end
        bbsy_in_h = 1'b0;
        tick();
        chk("bbsy_take", {sack_out_h, bbsy_out_h}, 2'b01);
        wait_sig(3, 1'b1, DESKEW + 5, n);
        chk("deskew_clocks", n, DESKEW);
    endtask

    task automatic slave(input int dly, input logic [15:0] data, input bit mid_go);
        for (int i = 0; i < dly; i++)
            if (mid_go && i == 5) arm_wr(4'd1, 32'h8000_0004);
            else tick();
        d_in_h = data;
        ssyn_in_h = 1'b1;
        tick();
        chk("msyn_drop_bbsy_held", {msyn_out_h, bbsy_out_h}, 2'b01);
        ssyn_in_h = 1'b0;
        d_in_h = '0;
        tick();
        chk("bbsy_release", bbsy_out_h, 0);
        tick();
        done_cycle(1'b0, !m_bus_c[1], data);
    endtask

    initial begin
        logic [31:0] r;
        int n;
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        chk("rst_bus", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h, armintrq}, 0);
        arm_rd(4'd0, r); chk("id_reg", r, 32'h444D1001);
        arm_rd(4'd1, r); chk("rst_reg1", r, 0);
        arm_rd(4'd2, r); chk("rst_reg2", r, 0);
        arm_rd(4'd3, r); chk("rst_reg3", r, 0);
        mon_bus = 1'b1;
        mon_idle = 1'b1;

        // DATI from 001000, slave answers 123456 after 20 clocks
        arm_wr(4'd1, {1'b1, 11'b0, 2'b00, 18'o001000});
        grant(2, 0);
        slave(20, 16'o123456, 1'b0);
        arm_rd(4'd2, r); chk("dati_reg2", r, 32'hA72E_0000);
        arm_rd(4'd2, r); chk("dati_model_reg2", r, {m_rdata, m_wdata});
        arm_rd(4'd3, r); chk("dati_reg3", r, 32'h4000_0000);
        arm_rd(4'd1, r); chk("dati_reg1", r, 32'h0000_0200);

        // DATO to 776700 with a GO+new address written mid-cycle
        arm_wr(4'd2, 32'h0000_5555);
        arm_wr(4'd1, {1'b1, 11'b0, 2'b10, 18'o776700});
        chk("dato_model_bus", {m_bus_addr, m_bus_d}, {18'h3FDC0, 16'h5555});
        grant(0, 0);
        slave(20, 16'hFFFF, 1'b1);
        repeat (5) tick();
        arm_rd(4'd1, r); chk("dato_go_ignored_reg1", r, 32'h0000_0004);
        arm_rd(4'd2, r); chk("dato_reg2", r, 32'hA72E_5555);
        arm_rd(4'd3, r); chk("dato_reg3", r, {m_busy, m_done, m_nxm, m_ie, 28'd0});

        // NXM with interrupts enabled
        arm_wr(4'd3, 32'h1000_0000);
        arm_wr(4'd1, {1'b1, 11'b0, 2'b00, 18'o017000});
        grant(1, 0);
        wait_sig(3, 1'b0, TIMEOUT + 10, n);
        chk("nxm_msyn_clocks", n, TIMEOUT);
        tick();
        chk("nxm_bbsy_release", bbsy_out_h, 0);
        tick();
        done_cycle(1'b1, 1'b0, 16'd0);
        chk("nxm_intrq", armintrq, 1);
        arm_rd(4'd3, r); chk("nxm_reg3", r, 32'h7000_0000);
        arm_wr(4'd3, 32'h5000_0000);
        arm_rd(4'd3, r); chk("clr_done_reg3", r, 32'h3000_0000);
        arm_wr(4'd3, 32'h2000_0000);
        arm_rd(4'd3, r); chk("clr_nxm_reg3", r, 32'h0000_0000);

        // long grant, then another master still holding BBSY
        arm_wr(4'd1, {1'b1, 11'b0, 2'b00, 18'o000100});
        grant(50, 10);
        slave(3, 16'o000007, 1'b0);
        arm_rd(4'd2, r); chk("arb_reg2", r, 32'h0007_5555);

        // INIT during MSYN
        arm_wr(4'd1, {1'b1, 11'b0, 2'b00, 18'o000200});
        grant(1, 0);
        repeat (3) tick();
        init_in_h = 1'b1;
        tick();
        init_in_h = 1'b0;
        chk("init_bus", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h}, 0);
        done_cycle(1'b1, 1'b0, 16'd0);
        arm_rd(4'd3, r); chk("init_reg3", r, 32'h6000_0000);
        arm_rd(4'd1, r); chk("init_reg1_kept", r, 32'h0000_0080);
        repeat (3) tick();

        // RESET during MSYN
        arm_wr(4'd3, 32'h1000_0000);
        arm_wr(4'd1, {1'b1, 11'b0, 2'b10, 18'o000300});
        grant(0, 0);
        repeat (2) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        {m_addr, m_c, m_wdata, m_rdata, m_ie, m_done, m_nxm, m_busy} = '0;
        chk("rst_mid_bus", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h, armintrq}, 0);
        arm_rd(4'd1, r); chk("rst_mid_reg1", r, 0);
        arm_rd(4'd2, r); chk("rst_mid_reg2", r, 0);
        arm_rd(4'd3, r); chk("rst_mid_reg3", r, 0);
        mon_idle = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
